// File: rtl/rv32i_pkg.sv
// Shared RV32I decode definitions: widths, base opcodes and immediate formats.
package rv32i_pkg;

    localparam int unsigned XLEN   = 32;
    localparam int unsigned NREGS  = 32;
    localparam int unsigned REG_AW = 5;

    localparam logic [6:0] OP_LUI    = 7'b0110111;
    localparam logic [6:0] OP_AUIPC  = 7'b0010111;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_JALR   = 7'b1100111;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_IMM    = 7'b0010011;
    localparam logic [6:0] OP_REG    = 7'b0110011;
    localparam logic [6:0] OP_SYSTEM = 7'b1110011;
    localparam logic [6:0] OP_FENCE  = 7'b0001111;

    typedef enum logic [2:0] {
        FMT_R,
        FMT_I,
        FMT_S,
        FMT_B,
        FMT_U,
        FMT_J
    } imm_fmt_t;

    // True for the base-ISA major opcodes this decoder understands.
    function automatic logic is_known_opcode(input logic [6:0] op);
        case (op)
            OP_LUI, OP_AUIPC, OP_JAL, OP_JALR, OP_BRANCH, OP_LOAD,
            OP_STORE, OP_IMM, OP_REG, OP_SYSTEM, OP_FENCE: is_known_opcode = 1'b1;
            default:                                        is_known_opcode = 1'b0;
        endcase
    endfunction

endpackage

// File: rtl/register_file.sv
// 2R1W architectural register file, x0 hardwired to zero, write-to-read bypass.
module register_file
    import rv32i_pkg::*;
(
    input  logic                clk,
    input  logic                rst,
    input  logic [REG_AW-1:0]   rs1_addr,
    input  logic [REG_AW-1:0]   rs2_addr,
    output logic [XLEN-1:0]     rs1_data,
    output logic [XLEN-1:0]     rs2_data,
    input  logic                we,
    input  logic [REG_AW-1:0]   wr_addr,
    input  logic [XLEN-1:0]     wr_data
);

    logic [XLEN-1:0] regs [1:NREGS-1];

    // Storage for x1..x31; writes to x0 are discarded.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 1; i < int'(NREGS); i++) begin
                regs[i] <= '0;
            end
        end else if (we && (wr_addr != '0)) begin
            regs[wr_addr] <= wr_data;
        end
    end

    // Read port 1: zero for x0, bypass a same-cycle write, else stored value.
    always_comb begin
        rs1_data = '0;
        if (rs1_addr != '0) begin
            if (we && (wr_addr == rs1_addr)) begin
                rs1_data = wr_data;
            end else begin
                rs1_data = regs[rs1_addr];
            end
        end
    end

    // Read port 2: same rules as port 1.
    always_comb begin
        rs2_data = '0;
        if (rs2_addr != '0) begin
            if (we && (wr_addr == rs2_addr)) begin
                rs2_data = wr_data;
            end else begin
                rs2_data = regs[rs2_addr];
            end
        end
    end

endmodule

// File: rtl/instruction_decode.sv
// RV32I decode stage: field extraction, immediate generation, register read,
// and a valid/ready ID/EX output register.
module instruction_decode
    import rv32i_pkg::*;
(
    input  logic                clk,
    input  logic                rst,
    input  logic                if_valid,
    input  logic [XLEN-1:0]     if_instruction,
    input  logic [XLEN-1:0]     if_pc,
    output logic                id_ready,
    input  logic                flush,
    input  logic                ex_ready,
    output logic                ex_valid,
    output logic [XLEN-1:0]     ex_pc,
    output logic [XLEN-1:0]     ex_rs1_data,
    output logic [XLEN-1:0]     ex_rs2_data,
    output logic [XLEN-1:0]     ex_imm,
    output logic [REG_AW-1:0]   ex_rd,
    output logic [6:0]          ex_opcode,
    output logic [2:0]          ex_funct3,
    output logic                ex_funct7b5,
    output logic                ex_illegal,
    input  logic                wb_we,
    input  logic [REG_AW-1:0]   wb_rd,
    input  logic [XLEN-1:0]     wb_data
);

    logic [XLEN-1:0] instr;
    logic [6:0]      opcode;
    logic [XLEN-1:0] rs1_val;
    logic [XLEN-1:0] rs2_val;
    logic [XLEN-1:0] imm;
    logic            illegal;
    logic            accept;
    imm_fmt_t        fmt;

    assign instr  = if_instruction;
    assign opcode = instr[6:0];

    assign id_ready = ~ex_valid | ex_ready;
    assign accept   = if_valid & id_ready;

    register_file u_register_file (
        .clk      (clk),
        .rst      (rst),
        .rs1_addr (instr[19:15]),
        .rs2_addr (instr[24:20]),
        .rs1_data (rs1_val),
        .rs2_data (rs2_val),
        .we       (wb_we),
        .wr_addr  (wb_rd),
        .wr_data  (wb_data)
    );

    // Unsupported compressed/unknown encodings are flagged but still passed on.
    assign illegal = (instr[1:0] != 2'b11) | ~is_known_opcode(opcode);

    // Pick the immediate format from the opcode and build the sign-extended value.
    always_comb begin
        fmt = FMT_R;
        imm = '0;
        case (opcode)
            OP_IMM, OP_LOAD, OP_JALR: fmt = FMT_I;
            OP_STORE:                 fmt = FMT_S;
            OP_BRANCH:                fmt = FMT_B;
            OP_LUI, OP_AUIPC:         fmt = FMT_U;
            OP_JAL:                   fmt = FMT_J;
            default:                  fmt = FMT_R;
        endcase
        case (fmt)
            FMT_I: imm = {{20{instr[31]}}, instr[31:20]};
            FMT_S: imm = {{20{instr[31]}}, instr[31:25], instr[11:7]};
            FMT_B: imm = {{19{instr[31]}}, instr[31], instr[7], instr[30:25], instr[11:8], 1'b0};
            FMT_U: imm = {instr[31:12], 12'b0};
            FMT_J: imm = {{11{instr[31]}}, instr[31], instr[19:12], instr[20], instr[30:21], 1'b0};
            default: imm = '0;
        endcase
    end

    // ID/EX register: flush kills, accept loads, otherwise drain on ex_ready or hold.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ex_valid    <= 1'b0;
            ex_pc       <= '0;
            ex_rs1_data <= '0;
            ex_rs2_data <= '0;
            ex_imm      <= '0;
            ex_rd       <= '0;
            ex_opcode   <= '0;
            ex_funct3   <= '0;
            ex_funct7b5 <= 1'b0;
            ex_illegal  <= 1'b0;
        end else if (flush) begin
            ex_valid <= 1'b0;
        end else if (accept) begin
            ex_valid    <= 1'b1;
            ex_pc       <= if_pc;
            ex_rs1_data <= rs1_val;
            ex_rs2_data <= rs2_val;
            ex_imm      <= imm;
            ex_rd       <= instr[11:7];
            ex_opcode   <= opcode;
            ex_funct3   <= instr[14:12];
            ex_funct7b5 <= instr[30];
            ex_illegal  <= illegal;
        end else if (ex_ready) begin
            ex_valid <= 1'b0;
        end
    end

endmodule

// File: tb/tb_instruction_decode.sv
// Directed self-checking bench for instruction_decode.
module tb_instruction_decode;

    logic        clk = 1'b0;
    logic        rst;
    logic        if_valid;
    logic [31:0] if_instruction;
    logic [31:0] if_pc;
    logic        id_ready;
    logic        flush;
    logic        ex_ready;
    logic        ex_valid;
    logic [31:0] ex_pc;
    logic [31:0] ex_rs1_data;
    logic [31:0] ex_rs2_data;
    logic [31:0] ex_imm;
    logic [4:0]  ex_rd;
    logic [6:0]  ex_opcode;
    logic [2:0]  ex_funct3;
    logic        ex_funct7b5;
    logic        ex_illegal;
    logic        wb_we;
    logic [4:0]  wb_rd;
    logic [31:0] wb_data;

    int checks = 0;
    int errors = 0;

    instruction_decode dut (
        .clk            (clk),
        .rst            (rst),
        .if_valid       (if_valid),
        .if_instruction (if_instruction),
        .if_pc          (if_pc),
        .id_ready       (id_ready),
        .flush          (flush),
        .ex_ready       (ex_ready),
        .ex_valid       (ex_valid),
        .ex_pc          (ex_pc),
        .ex_rs1_data    (ex_rs1_data),
        .ex_rs2_data    (ex_rs2_data),
        .ex_imm         (ex_imm),
        .ex_rd          (ex_rd),
        .ex_opcode      (ex_opcode),
        .ex_funct3      (ex_funct3),
        .ex_funct7b5    (ex_funct7b5),
        .ex_illegal     (ex_illegal),
        .wb_we          (wb_we),
        .wb_rd          (wb_rd),
        .wb_data        (wb_data)
    );

    always #5 clk = ~clk;

    // Count one comparison and report it if it differs.
    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=0x%08h exp=0x%08h", tag, got, exp);
        end
    endtask

    // Advance one clock and settle just past the edge.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic issue(input logic [31:0] ins, input logic [31:0] pc);
        if_valid       = 1'b1;
        if_instruction = ins;
        if_pc          = pc;
        step();
    endtask

    logic [31:0] held_pc;
    logic [31:0] held_rs1;
    logic [31:0] held_imm;
    logic [31:0] rinstr;

    initial begin
        rst = 1'b1; if_valid = 1'b0; if_instruction = '0; if_pc = '0;
        flush = 1'b0; ex_ready = 1'b1; wb_we = 1'b0; wb_rd = '0; wb_data = '0;
        step(); step();
        check("rst_valid", 32'(ex_valid), 32'd0);
        check("rst_imm", ex_imm, 32'd0);
        check("rst_id_ready", 32'(id_ready), 32'd1);
        #2 rst = 1'b0;
        step();

        // addi x1,x0,5
        issue(32'h00500093, 32'h100);
        check("addi_valid", 32'(ex_valid), 32'd1);
        check("addi_imm", ex_imm, 32'd5);
        check("addi_rd", 32'(ex_rd), 32'd1);
        check("addi_rs1", ex_rs1_data, 32'd0);
        check("addi_opcode", 32'(ex_opcode), 32'h13);
        check("addi_illegal", 32'(ex_illegal), 32'd0);
        check("addi_pc", ex_pc, 32'h100);

        // write x2 = 0x11 with no fetch
        if_valid = 1'b0; wb_we = 1'b1; wb_rd = 5'd2; wb_data = 32'h11;
        step();
        check("drain_valid", 32'(ex_valid), 32'd0);
        wb_we = 1'b0;

        // sw x2,8(x1)
        issue(32'h0020A423, 32'h104);
        check("sw_imm", ex_imm, 32'd8);
        check("sw_rs2", ex_rs2_data, 32'h11);
        check("sw_rs1", ex_rs1_data, 32'd0);
        check("sw_funct3", 32'(ex_funct3), 32'd2);

        issue(32'hFE000EE3, 32'h108);
        check("beq_imm", ex_imm, 32'hFFFFFFFC);

        issue(32'h123452B7, 32'h10C);
        check("lui_imm", ex_imm, 32'h12345000);
        check("lui_rd", 32'(ex_rd), 32'd5);

        // jal x1,8
        issue(32'h008000EF, 32'h110);
        check("jal_imm", ex_imm, 32'd8);

        // add x3,x1,x2 with same-cycle write of x1
        wb_we = 1'b1; wb_rd = 5'd1; wb_data = 32'hDEADBEEF;
        issue(32'h002081B3, 32'h114);
        check("byp_rs1", ex_rs1_data, 32'hDEADBEEF);
        check("byp_rs2", ex_rs2_data, 32'h11);
        check("add_f7b5", 32'(ex_funct7b5), 32'd0);

        // write to x0 ignored, add x3,x0,x0
        wb_rd = 5'd0; wb_data = 32'h55;
        issue(32'h000001B3, 32'h118);
        check("x0_byp", ex_rs1_data, 32'd0);
        wb_we = 1'b0;
        issue(32'h000001B3, 32'h11C);
        check("x0_after", ex_rs1_data, 32'd0);

        // add x3,x1,x2: x1 retained the bypassed write
        issue(32'h002081B3, 32'h120);
        check("x1_stored", ex_rs1_data, 32'hDEADBEEF);

        // backpressure: hold the entry, write x1 meanwhile
        held_pc = ex_pc; held_rs1 = ex_rs1_data; held_imm = ex_imm;
        ex_ready = 1'b0;
        if_valid = 1'b1; if_instruction = 32'h00500093; if_pc = 32'h124;
        wb_we = 1'b1; wb_rd = 5'd1; wb_data = 32'h1234;
        #1;
        check("bp_id_ready", 32'(id_ready), 32'd0);
        for (int c = 0; c < 3; c++) begin
            step();
            wb_we = 1'b0;
            check("bp_valid", 32'(ex_valid), 32'd1);
            check("bp_pc", ex_pc, held_pc);
            check("bp_rs1", ex_rs1_data, held_rs1);
            check("bp_imm", ex_imm, held_imm);
        end
        ex_ready = 1'b1;
        #1;
        check("bp_release_ready", 32'(id_ready), 32'd1);
        step();
        check("bp_next_pc", ex_pc, 32'h124);
        check("bp_next_imm", ex_imm, 32'd5);
        check("bp_next_valid", 32'(ex_valid), 32'd1);

        // flush beats simultaneous accept
        flush = 1'b1;
        issue(32'h123452B7, 32'h128);
        check("flush_valid", 32'(ex_valid), 32'd0);
        flush = 1'b0; if_valid = 1'b0;
        step();
        check("flush_dropped", 32'(ex_valid), 32'd0);

        // illegal all-zero word
        issue(32'h00000000, 32'h12C);
        check("ill_valid", 32'(ex_valid), 32'd1);
        check("ill_flag", 32'(ex_illegal), 32'd1);
        check("ill_imm", ex_imm, 32'd0);

        // asynchronous reset mid-stream
        issue(32'h002081B3, 32'h130);
        check("pre_rst_valid", 32'(ex_valid), 32'd1);
        #2 rst = 1'b1;
        #1;
        check("arst_valid", 32'(ex_valid), 32'd0);
        check("arst_pc", ex_pc, 32'd0);
        check("arst_rs1", ex_rs1_data, 32'd0);
        check("arst_rs2", ex_rs2_data, 32'd0);
        check("arst_rd", 32'(ex_rd), 32'd0);
        check("arst_opcode", 32'(ex_opcode), 32'd0);
        #1 rst = 1'b0;
        step();

        // every register reads zero after reset
        for (int r = 1; r < 32; r++) begin
            rinstr = {7'b0, 5'(r), 5'(r), 3'b000, 5'd0, 7'b0110011};
            issue(rinstr, 32'h200 + 32'(4 * r));
            check("rf_rst_rs1", ex_rs1_data, 32'd0);
            check("rf_rst_rs2", ex_rs2_data, 32'd0);
        end

        if_valid = 1'b0;
        step();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/instruction_decode.md
Name: instruction_decode

Overview:
- RV32I decode stage. Sits directly downstream of instruction_fetch and consumes its instruction word and PC.
- Contains the 32x32 architectural register file, immediate generation and field extraction.
- Registers the decoded result into an ID/EX output register with a valid/ready handshake.
- The writeback port from the later stage writes the register file, with same-cycle bypass to decode reads.

Parameters:
- XLEN, 32, datapath and register width
- NREGS, 32, number of architectural registers (x0 hardwired to zero)

Ports:
- clk  input  1  clock, rising edge
- rst  input  1  asynchronous reset, active-high
- if_valid  input  1  fetch presents a valid instruction
- if_instruction  input  32  instruction word from fetch
- if_pc  input  32  PC of if_instruction
- id_ready  output  1  decode accepts this cycle (fetch stalls when low)
- flush  input  1  kill the held ID/EX entry (branch redirect)
- ex_ready  input  1  execute accepts the ID/EX entry
- ex_valid  output  1  ID/EX entry valid
- ex_pc  output  32  PC of the entry
- ex_rs1_data  output  32  rs1 operand
- ex_rs2_data  output  32  rs2 operand
- ex_imm  output  32  sign-extended immediate
- ex_rd  output  5  destination register
- ex_opcode  output  7  instruction[6:0]
- ex_funct3  output  3  instruction[14:12]
- ex_funct7b5  output  1  instruction[30]
- ex_illegal  output  1  unsupported encoding
- wb_we  input  1  writeback enable
- wb_rd  input  5  writeback register
- wb_data  input  32  writeback value

Behaviour:
- Reset (rst=1, asynchronous): ex_valid=0; all ex_* data outputs=0; all registers x1..x31=0.
- Handshake:
  - id_ready = ~ex_valid | ex_ready (combinational).
  - Accept when if_valid & id_ready. Latency 1 cycle: the entry appears on ex_* at the next edge with ex_valid=1.
  - if_valid & id_ready=0: nothing captured; fetch must hold its inputs.
- Output register stability: while ex_valid & ~ex_ready, every ex_* output holds constant.
- Drain: ex_ready=1 with no accept clears ex_valid to 0 at the next edge.
- flush: at the next edge ex_valid=0, regardless of if_valid or ex_ready. flush has priority over a simultaneous accept; the flushed instruction is dropped. Data fields may update; their values are don't-care.
- Register file:
  - Read combinationally at rs1=instr[19:15], rs2=instr[24:20].
  - x0 always reads 0. Writes with wb_rd=0 are ignored.
  - Write on the clock edge when wb_we=1.
- Bypass: if wb_we & wb_rd!=0 & wb_rd==rs, the read returns wb_data in the same cycle. The captured operand is therefore the new value.
- Immediates, selected by opcode, all sign-extended from instr[31]:
  - I (0010011, 0000011, 1100111): instr[31:20]
  - S (0100011): {instr[31:25], instr[11:7]}
  - B (1100011): {instr[31], instr[7], instr[30:25], instr[11:8], 0}
  - U (0110111, 0010111): {instr[31:12], 12'b0}
  - J (1101111): {instr[31], instr[19:12], instr[20], instr[30:21], 0}
  - R (0110011) and illegal encodings: imm=0.
- ex_rd = instr[11:7] for all formats. Execute ignores it for S and B.
- ex_illegal=1 when instr[1:0]!=2'b11, or the opcode is outside {0110011, 0010011, 0000011, 0100011, 1100011, 1101111, 1100111, 0110111, 0010111, 1110011, 0001111}. Illegal entries still pass with ex_valid=1.
- A writeback to a register while a dependent entry is held stalled does not update the held operands; forwarding is execute's job.

Decomposition:
- Package rv32i_pkg holds:
  - opcode localparams (OP_LUI, OP_AUIPC, OP_JAL, OP_JALR, OP_BRANCH, OP_LOAD, OP_STORE, OP_IMM, OP_REG, OP_SYSTEM, OP_FENCE)
  - imm_fmt_t enum {FMT_R, FMT_I, FMT_S, FMT_B, FMT_U, FMT_J}
  - XLEN
- One sub-module: register_file. It has 2 read ports and 1 write port, x0 hardwired, and includes the bypass.
- Immediate generation stays inline.

Test Plan:
- Reset: assert rst mid-stream with ex_valid=1 -> ex_valid=0 and ex_*=0 immediately (asynchronous); after release, x1..x31 read 0.
- Immediate and field extraction:
  - 0x00500093 (addi x1,x0,5), ex_ready=1 -> next cycle ex_valid=1, ex_imm=5, ex_rd=1, ex_rs1_data=0
  - 0x0020A423 (sw x2,8(x1)) -> ex_imm=8
  - 0xFE000EE3 (beq x0,x0,-4) -> ex_imm=0xFFFFFFFC
  - 0x123452B7 (lui x5) -> ex_imm=0x12345000
- Bypass: wb_we=1, wb_rd=1, wb_data=0xDEADBEEF in the same cycle as 0x002081B3 (add x3,x1,x2) -> ex_rs1_data=0xDEADBEEF; wb_rd=0 write -> x0 still reads 0.
- Backpressure: ex_ready=0 with ex_valid=1 -> id_ready=0 and ex_* stable for 3 cycles; ex_ready=1 -> next instruction captured the following cycle.
- flush together with if_valid=1 and ex_ready=1 -> ex_valid=0 next cycle, and the instruction is not presented.
- Illegal: instruction 0x00000000 -> ex_valid=1, ex_illegal=1, ex_imm=0.
